// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
//   Shifts a programmable bit pattern out MSB-first on ser_out, one bit per clock,
//   repeated a programmable number of times with idle-zero gaps between repetitions.
//   Intended to drive the x1 input of a sequence detector or act as a pattern source.
//
// Optional feature: define SPG_PARITY_EN to append an even-parity bit
// (^pattern[len-1:0]) after every repetition (PAR state).
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   start    in   transfer request, sampled only while idle
//   abort    in   cancel the current transfer (no done pulse)
//   pattern  in   [PAT_W-1:0] bits to send; pattern[len-1] first, pattern[0] last
//   len      in   [LEN_W-1:0] pattern length 1..PAT_W (larger values clamp to PAT_W)
//   reps     in   [REP_W-1:0] repetitions; 0 repeats until abort
//   gap      in   [GAP_W-1:0] zero cycles between repetitions
//   ser_out  out  registered serial bit
//   busy     out  high while a transfer is in progress
//   done     out  one-cycle pulse after normal completion
module serial_pattern_gen #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

`ifdef SPG_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StGap, StPar} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;
`endif

    state_e state_q, state_d;

    logic             ser_q, ser_d;
    logic             done_q, done_d;
    logic [PAT_W-1:0] pat_q, pat_d;      // latched pattern, left-aligned to the MSB
    logic [PAT_W-1:0] shreg_q, shreg_d;  // working copy, shifted left each bit
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;      // bits still to send after the current one
    logic [REP_W-1:0] rem_q, rem_d;      // repetitions left; 0 means endless
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`ifdef SPG_PARITY_EN
    logic             par_q, par_d;
`endif

    logic [LEN_W-1:0] len_clamped;
    logic [PAT_W-1:0] aligned;
    logic             rep_end;

    assign len_clamped = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    // Left-aligning drops bits above len-1, so the MSB is always the first bit out
    // and the XOR of the aligned word is the parity of the active bits only.
    assign aligned = pattern << (LEN_W'(PAT_W) - len_clamped);

    always_comb begin
        state_d   = state_q;
        ser_d     = 1'b0;
        done_d    = 1'b0;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
`ifdef SPG_PARITY_EN
        par_d     = par_q;
`endif
        rep_end   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort && (len != '0)) begin
                    pat_d   = aligned;
                    len_d   = len_clamped;
                    rem_d   = reps;
                    gap_d   = gap;
`ifdef SPG_PARITY_EN
                    par_d   = ^aligned;
`endif
                    ser_d   = aligned[PAT_W-1];
                    shreg_d = aligned << 1;
                    cnt_d   = len_clamped - LEN_W'(1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    ser_d   = shreg_q[PAT_W-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - LEN_W'(1);
                end else begin
`ifdef SPG_PARITY_EN
                    ser_d   = par_q;
                    state_d = StPar;
`else
                    rep_end = 1'b1;
`endif
                end
            end
`ifdef SPG_PARITY_EN
            StPar: begin
                rep_end = 1'b1;
            end
`endif
            StGap: begin
                if (gap_cnt_q == '0) begin
                    ser_d   = pat_q[PAT_W-1];
                    shreg_d = pat_q << 1;
                    cnt_d   = len_q - LEN_W'(1);
                    state_d = StShift;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Last bit of a repetition has just been sent: finish, gap, or restart.
        if (rep_end) begin
            if (rem_q == REP_W'(1)) begin
                done_d  = 1'b1;
                state_d = StIdle;
            end else begin
                if (rem_q != '0) begin
                    rem_d = rem_q - REP_W'(1);
                end
                if (gap_q != '0) begin
                    gap_cnt_d = gap_q - GAP_W'(1);
                    state_d   = StGap;
                end else begin
                    // Back-to-back repetition, no dead cycle.
                    ser_d   = pat_q[PAT_W-1];
                    shreg_d = pat_q << 1;
                    cnt_d   = len_q - LEN_W'(1);
                    state_d = StShift;
                end
            end
        end

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            ser_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ser_q     <= 1'b0;
            done_q    <= 1'b0;
            pat_q     <= '0;
            shreg_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
`ifdef SPG_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ser_q     <= ser_d;
            done_q    <= done_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef SPG_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign ser_out = ser_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// tb_serial_pattern_gen
//   Directed test of serial_pattern_gen with hand-computed bit sequences.
//   "Cycle n" is the interval after rising edge n; outputs are sampled 1 time unit
//   after each rising edge and inputs are changed at the same point.
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       ser_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    serial_pattern_gen #(
        .PAT_W(8),
        .LEN_W(4),
        .REP_W(4),
        .GAP_W(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .pattern(pattern),
        .len    (len),
        .reps   (reps),
        .gap    (gap),
        .ser_out(ser_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns in the first bit cycle.
    task automatic start_xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                              input logic [3:0] g);
        pattern = p;
        len     = l;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // exp[n-1] is expected first; returns in the cycle after the last bit.
    task automatic expect_bits(input string tag, input logic [31:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            check_val($sformatf("%s ser[%0d]", tag, n - 1 - i), {31'd0, ser_out}, {31'd0, exp[i]});
            check_val($sformatf("%s busy[%0d]", tag, n - 1 - i), {31'd0, busy}, 32'd1);
            check_val($sformatf("%s done[%0d]", tag, n - 1 - i), {31'd0, done}, 32'd0);
            tick();
        end
    endtask

    task automatic expect_outs(input string tag, input logic s, input logic b, input logic d);
        check_val({tag, " ser"}, {31'd0, ser_out}, {31'd0, s});
        check_val({tag, " busy"}, {31'd0, busy}, {31'd0, b});
        check_val({tag, " done"}, {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;
        tick();
        tick();
        expect_outs("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_outs("idle", 1'b0, 1'b0, 1'b0);

        // 0x0D, len 4, single repetition.
        start_xfer(8'h0D, 4'd4, 4'd1, 4'd0);
`ifdef SPG_PARITY_EN
        expect_bits("single", 32'b11011, 5);
`else
        expect_bits("single", 32'b1101, 4);
`endif
        expect_outs("single end", 1'b0, 1'b0, 1'b1);

        // Start in the done cycle is accepted: two repetitions with gap 2.
        start_xfer(8'h0D, 4'd4, 4'd2, 4'd2);
`ifdef SPG_PARITY_EN
        expect_bits("rep2gap2", 32'b110110011011, 12);
`else
        expect_bits("rep2gap2", 32'b1101001101, 10);
`endif
        expect_outs("rep2gap2 end", 1'b0, 1'b0, 1'b1);
        tick();
        expect_outs("rep2gap2 after", 1'b0, 1'b0, 1'b0);

        // Gap 0: repetitions run back to back.
        start_xfer(8'h06, 4'd3, 4'd2, 4'd0);
`ifdef SPG_PARITY_EN
        expect_bits("rep2gap0", 32'b11001100, 8);
`else
        expect_bits("rep2gap0", 32'b110110, 6);
`endif
        expect_outs("rep2gap0 end", 1'b0, 1'b0, 1'b1);
        tick();

        // Endless repetition of 101, aborted while cycle 7 is on the line.
        start_xfer(8'h05, 4'd3, 4'd0, 4'd0);
`ifdef SPG_PARITY_EN
        expect_bits("endless", 32'b101010, 6);
`else
        expect_bits("endless", 32'b101101, 6);
`endif
        expect_outs("endless c7", 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_outs("abort c8", 1'b0, 1'b0, 1'b0);
        tick();
        expect_outs("abort c9", 1'b0, 1'b0, 1'b0);

        // Inputs change after the start edge; a second start mid-transfer is ignored.
        start_xfer(8'h0D, 4'd4, 4'd1, 4'd0);
        pattern = 8'hFF;
        len     = 4'd2;
        reps    = 4'd3;
        expect_bits("restart c1", 32'b1, 1);
        start = 1'b1;
        expect_outs("restart c2", 1'b1, 1'b1, 1'b0);
        tick();
        start = 1'b0;
`ifdef SPG_PARITY_EN
        expect_bits("restart tail", 32'b011, 3);
`else
        expect_bits("restart tail", 32'b01, 2);
`endif
        expect_outs("restart end", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_outs($sformatf("restart quiet%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // len 0 is ignored.
        start_xfer(8'hFF, 4'd0, 4'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            expect_outs($sformatf("len0 c%0d", i), 1'b0, 1'b0, 1'b0);
            tick();
        end

        // abort together with start in idle: abort wins.
        abort = 1'b1;
        start_xfer(8'hFF, 4'd4, 4'd1, 4'd0);
        abort = 1'b0;
        expect_outs("abort+start", 1'b0, 1'b0, 1'b0);
        tick();
        expect_outs("abort+start2", 1'b0, 1'b0, 1'b0);

        // len above PAT_W clamps to 8 bits.
        start_xfer(8'hA5, 4'd15, 4'd1, 4'd0);
`ifdef SPG_PARITY_EN
        expect_bits("clamp", 32'b101001010, 9);
`else
        expect_bits("clamp", 32'b10100101, 8);
`endif
        expect_outs("clamp end", 1'b0, 1'b0, 1'b1);
        tick();

        // Reset during cycle 3, then a normal transfer.
        start_xfer(8'h0D, 4'd4, 4'd1, 4'd0);
        expect_bits("rst pre", 32'b11, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_outs("rst c4", 1'b0, 1'b0, 1'b0);
        tick();
        expect_outs("rst c5", 1'b0, 1'b0, 1'b0);
        start_xfer(8'h0D, 4'd4, 4'd1, 4'd0);
`ifdef SPG_PARITY_EN
        expect_bits("post rst", 32'b11011, 5);
`else
        expect_bits("post rst", 32'b1101, 4);
`endif
        expect_outs("post rst end", 1'b0, 1'b0, 1'b1);
        tick();
        expect_outs("post rst idle", 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
